// File: rtl/sram_like_pkg.sv
// Shared definitions for the sram-like bus responder.
// Transfer sizes, lane enables and alignment rules.
package sram_like_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int AGE_W = 4;

    function automatic logic [3:0] byte_en(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic [3:0] be;
        be = 4'b1111;
        unique case (size)
            SIZE_BYTE: be = 4'b0001 << lo;
            SIZE_HALF: be = 4'b0011 << lo;
            default:   be = 4'b1111;
        endcase
        return be;
    endfunction

    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        logic m;
        m = 1'b0;
        unique case (size)
            SIZE_BYTE: m = 1'b0;
            SIZE_HALF: m = lo[0];
            default:   m = (lo != 2'b00);
        endcase
        return m;
    endfunction

endpackage

// File: rtl/sram_like_resp_queue.sv
// In-order response FIFO with per-entry ageing.
// Head is ready once it has waited LATENCY cycles.
module sram_like_resp_queue
    import sram_like_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        push,
    input  logic [31:0] push_data,
    input  logic        pop,
    output logic [3:0]  count,
    output logic [31:0] head_data,
    output logic        head_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [AGE_W-1:0] LAT_A = AGE_W'(LATENCY);

    logic [31:0]      data_q  [DEPTH];
    logic [AGE_W-1:0] age_q   [DEPTH];
    logic             valid_q [DEPTH];
    logic [PW-1:0]    head_q;
    logic [PW-1:0]    tail_q;
    logic [3:0]       count_q;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    assign count      = count_q;
    assign head_data  = data_q[head_q];
    assign head_ready = valid_q[head_q] && (age_q[head_q] == LAT_A);

    // Age live entries, retire the head, append new entries at the tail.
    // A new entry starts at age 1: one cycle has elapsed when it is visible.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                age_q[i]   <= '0;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && (age_q[i] != LAT_A))
                    age_q[i] <= age_q[i] + AGE_W'(1);
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                head_q          <= wrap_inc(head_q);
            end
            if (push) begin
                valid_q[tail_q] <= 1'b1;
                age_q[tail_q]   <= AGE_W'(1);
                data_q[tail_q]  <= push_data;
                tail_q          <= wrap_inc(tail_q);
            end
            if (push && !pop)
                count_q <= count_q + 4'd1;
            else if (pop && !push)
                count_q <= count_q - 4'd1;
        end
    end

endmodule

// File: rtl/sram_like_slave.sv
// Responder end of one sram-like port: word RAM,
// fixed response latency and bounded outstanding requests.
module sram_like_slave
    import sram_like_pkg::*;
#(
    parameter int MEM_AW  = 12,
    parameter int LATENCY = 2,
    parameter int DEPTH   = 2
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        stall_inject,
    output logic        addr_ok,
    output logic        data_ok,
    output logic [31:0] rdata,
    output logic        misalign_err,
    output logic [3:0]  outstanding
);

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [31:0]       mem [2**MEM_AW];
    logic [MEM_AW-1:0] word_idx;
    logic [31:0]       cur_word;
    logic [31:0]       head_data;
    logic [3:0]        be;
    logic [3:0]        count;
    logic              accept;
    logic              mis;
    logic              head_ready;
    logic              unused_addr_hi;

    assign word_idx       = addr[MEM_AW+1:2];
    assign unused_addr_hi = ^addr[31:MEM_AW+2];
    assign cur_word       = mem[word_idx];
    assign be             = byte_en(size, addr[1:0]);
    assign mis            = misaligned(size, addr[1:0]);

    // Occupancy alone gates acceptance; a same-cycle pop does not help.
    assign addr_ok      = rstn && !stall_inject && (count < DEPTH_C);
    assign accept       = req && addr_ok;
    assign misalign_err = accept && mis;
    assign data_ok      = head_ready;
    assign rdata        = head_ready ? head_data : '0;
    assign outstanding  = count;

    // Lane writes commit at the accept edge; misaligned writes are dropped.
    always_ff @(posedge clk) begin
        if (accept && wr && !mis) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b])
                    mem[word_idx][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    sram_like_resp_queue #(
        .LATENCY (LATENCY),
        .DEPTH   (DEPTH)
    ) u_queue (
        .clk        (clk),
        .rstn       (rstn),
        .push       (accept),
        .push_data  (cur_word),
        .pop        (head_ready),
        .count      (count),
        .head_data  (head_data),
        .head_ready (head_ready)
    );

endmodule

// File: tb/tb_sram_like_slave.sv
// Scoreboard bench for sram_like_slave: two instances,
// (LATENCY=2, DEPTH=2) and (LATENCY=1, DEPTH=1).
module tb_sram_like_slave;

    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstn    [2];
    logic        req     [2];
    logic        wr      [2];
    logic [1:0]  size    [2];
    logic [31:0] addr    [2];
    logic [31:0] wdata   [2];
    logic        stall   [2];
    logic        addr_ok [2];
    logic        data_ok [2];
    logic [31:0] rdata   [2];
    logic        mis_err [2];
    logic [3:0]  outst   [2];

    sram_like_slave #(.MEM_AW(AW), .LATENCY(2), .DEPTH(2)) u_a (
        .clk(clk), .rstn(rstn[0]), .req(req[0]), .wr(wr[0]),
        .size(size[0]), .addr(addr[0]), .wdata(wdata[0]),
        .stall_inject(stall[0]), .addr_ok(addr_ok[0]),
        .data_ok(data_ok[0]), .rdata(rdata[0]),
        .misalign_err(mis_err[0]), .outstanding(outst[0])
    );

    sram_like_slave #(.MEM_AW(AW), .LATENCY(1), .DEPTH(1)) u_b (
        .clk(clk), .rstn(rstn[1]), .req(req[1]), .wr(wr[1]),
        .size(size[1]), .addr(addr[1]), .wdata(wdata[1]),
        .stall_inject(stall[1]), .addr_ok(addr_ok[1]),
        .data_ok(data_ok[1]), .rdata(rdata[1]),
        .misalign_err(mis_err[1]), .outstanding(outst[1])
    );

    function automatic int lat_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    function automatic int dep_of(int i);
        return (i == 0) ? 2 : 1;
    endfunction

    typedef struct {
        int          inst;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sbq [$];
    logic [31:0] mm [2][2**AW];
    int          cyc    = 0;
    int          checks = 0;
    int          errors = 0;
    bit          accf [2];
    bit          rnd_st = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s inst=%0d cyc=%0d got=%h exp=%h",
                     nm, i, cyc, act, exp);
        end
    endtask

    // Monitor: mid-cycle, compare outputs to the reference and advance it.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            int h;
            int n;
            int nb;
            int lane;
            bit e_ok;
            bit e_dv;
            bit e_mis;
            bit acc;
            logic [AW-1:0] idx;
            h = -1;
            n = 0;
            for (int k = 0; k < sbq.size(); k++) begin
                if (sbq[k].inst == i) begin
                    if (h < 0) h = k;
                    n++;
                end
            end
            if (!rstn[i]) begin
                chk("rst_addr_ok", i, 32'(addr_ok[i]), 32'd0);
                chk("rst_data_ok", i, 32'(data_ok[i]), 32'd0);
                chk("rst_rdata", i, rdata[i], 32'd0);
                chk("rst_misalign", i, 32'(mis_err[i]), 32'd0);
                chk("rst_outstanding", i, 32'(outst[i]), 32'd0);
                for (int k = sbq.size() - 1; k >= 0; k--) begin
                    if (sbq[k].inst == i) sbq.delete(k);
                end
                accf[i] = 1'b0;
            end else begin
                e_ok = !stall[i] && (n < dep_of(i));
                e_dv = (h >= 0) && (sbq[h].due == cyc);
                chk("addr_ok", i, 32'(addr_ok[i]), 32'(e_ok));
                chk("outstanding", i, 32'(outst[i]), 32'(n));
                chk("data_ok", i, 32'(data_ok[i]), 32'(e_dv));
                if (e_dv) chk("rdata", i, rdata[i], sbq[h].data);
                acc = req[i] && e_ok;
                e_mis = acc && (((size[i] == 2'd1) && addr[i][0]) ||
                                ((size[i] >= 2'd2) && (addr[i][1:0] != 2'd0)));
                chk("misalign_err", i, 32'(mis_err[i]), 32'(e_mis));
                if (acc) begin
                    idx = addr[i][AW+1:2];
                    sbq.push_back('{i, mm[i][idx], cyc + lat_of(i)});
                    if (wr[i] && !e_mis) begin
                        nb = (size[i] == 2'd0) ? 1 : (size[i] == 2'd1) ? 2 : 4;
                        for (int k = 0; k < nb; k++) begin
                            lane = int'(addr[i][1:0]) + k;
                            mm[i][idx][8*lane +: 8] = wdata[i][8*lane +: 8];
                        end
                    end
                end
                if (e_dv) sbq.delete(h);
                accf[i] = acc;
            end
        end
    end

    task automatic start(int i, bit w, logic [1:0] sz,
                         logic [31:0] a, logic [31:0] d);
        req[i]   = 1'b1;
        wr[i]    = w;
        size[i]  = sz;
        addr[i]  = a;
        wdata[i] = d;
    endtask

    task automatic wait_acc(int i);
        int t;
        bit done;
        t = 0;
        done = 1'b0;
        while (!done) begin
            @(posedge clk);
            #1;
            done = accf[i];
            if (rnd_st) stall[i] = ($urandom_range(0, 3) == 0);
            t++;
            if (!done && t > 60) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout inst=%0d cyc=%0d got=none exp=accept",
                         i, cyc);
                done = 1'b1;
            end
        end
        req[i] = 1'b0;
    endtask

    task automatic issue(int i, bit w, logic [1:0] sz,
                         logic [31:0] a, logic [31:0] d);
        start(i, w, sz, a, d);
        wait_acc(i);
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic init_mem(int i);
        logic [31:0] a;
        for (int k = 0; k < 2**AW; k++) begin
            a = $urandom;
            a[AW+1:0] = {8'(k), 2'b00};
            issue(i, 1'b1, 2'd2, a, $urandom);
        end
    endtask

    task automatic directed_a();
        idle(3);
        issue(0, 1'b1, 2'd2, 32'h0000_0100, 32'h1234_5678);
        issue(0, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
        idle(3);
        issue(0, 1'b1, 2'd0, 32'h0000_0101, 32'h0000_AB00);
        issue(0, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
        issue(0, 1'b1, 2'd1, 32'h0000_0102, 32'hBEEF_0000);
        issue(0, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
        idle(4);
        for (int k = 0; k < 4; k++)
            issue(0, 1'b0, 2'd2, 32'h0000_0100 + 32'(4 * k), 32'h0);
        idle(4);
        issue(0, 1'b1, 2'd2, 32'h0000_0102, 32'hDEAD_BEEF);
        issue(0, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
        idle(4);
        issue(0, 1'b0, 2'd2, 32'h0000_0100, 32'h0);
        stall[0] = 1'b1;
        start(0, 1'b0, 2'd2, 32'h0000_0104, 32'h0);
        idle(5);
        stall[0] = 1'b0;
        wait_acc(0);
    endtask

    task automatic directed_b();
        idle(3);
        issue(1, 1'b1, 2'd2, 32'h0000_0040, 32'hCAFE_F00D);
        issue(1, 1'b1, 2'd0, 32'h0000_0043, 32'h5A00_0000);
        idle(2);
        issue(1, 1'b0, 2'd2, 32'h0000_0044, 32'h0);
        rstn[1] = 1'b0;
        idle(1);
        rstn[1] = 1'b1;
        idle(3);
        issue(1, 1'b0, 2'd2, 32'h0000_0040, 32'h0);
        issue(1, 1'b0, 2'd1, 32'h0000_0042, 32'h0);
        issue(1, 1'b1, 2'd1, 32'h0000_0041, 32'hFFFF_FFFF);
        issue(1, 1'b0, 2'd2, 32'h0000_0040, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            rstn[i]  = 1'b0;
            req[i]   = 1'b0;
            wr[i]    = 1'b0;
            size[i]  = 2'd0;
            addr[i]  = 32'h0;
            wdata[i] = 32'h0;
            stall[i] = 1'b0;
            accf[i]  = 1'b0;
        end
        idle(3);
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        fork
            begin init_mem(0); directed_a(); end
            begin init_mem(1); directed_b(); end
        join
        idle(2);
        rnd_st = 1'b1;
        for (int k = 0; k < 300; k++) begin
            logic [31:0] a;
            a = $urandom;
            issue(0, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  a, $urandom);
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        rnd_st = 1'b0;
        stall[0] = 1'b0;
        begin
            int t;
            t = 0;
            while (sbq.size() > 0 && t < 100) begin
                @(posedge clk);
                t++;
            end
            checks++;
            if (sbq.size() != 0) begin
                errors++;
                $display("FAIL drain got=%0d exp=0 pending responses", sbq.size());
            end
        end
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_like_slave.md
Name: sram_like_slave

Overview:
- Responder end of the sram-like bus that the CPU datapath drives (req/wr/size/addr/wdata out; rdata/addr_ok/data_ok in).
- Models the instruction or data memory behind one sram-like port.
- Provides a word-organised backing RAM, configurable response latency, a bounded number of outstanding requests, and a backpressure-injection hook so pipeline stall logic can be exercised in simulation.
- One instance per port (inst, data).

Parameters:
- MEM_AW, 12, log2 of RAM depth in 32-bit words; word index = addr[MEM_AW+1:2], upper address bits ignored (aliasing).
- LATENCY, 2, cycles from accept to data_ok; legal range 1..8.
- DEPTH, 2, maximum outstanding (accepted, not yet answered) requests; legal range 1..8.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- req  in  1  request valid.
- wr  in  1  1 = write, 0 = read.
- size  in  2  0 = byte, 1 = halfword, 2 = word; 3 is reserved and treated as word.
- addr  in  32  byte address.
- wdata  in  32  write data, lane-aligned: the byte at addr[1:0] sits in bits [8*addr[1:0]+7 : 8*addr[1:0]].
- stall_inject  in  1  forces addr_ok low (test hook).
- addr_ok  out  1  request accepted this cycle when req && addr_ok.
- data_ok  out  1  one-cycle response strobe.
- rdata  out  32  full aligned word; valid only while data_ok=1.
- misalign_err  out  1  one-cycle pulse on accept of a misaligned request.
- outstanding  out  4  current queue occupancy.

Behaviour:
- Clock and reset: single clock clk; asynchronous active-low reset rstn.
- Reset values: addr_ok=0 while rstn=0; data_ok=0, rdata=0, misalign_err=0, outstanding=0. RAM contents are not reset.
- addr_ok = rstn && !stall_inject && (outstanding < DEPTH). It is combinational from registered occupancy only, with no path from req. It does not count a same-cycle pop.
- Accept: the memory operation executes in the accept cycle.
  - Write: commits at the accept edge.
  - Read: samples the RAM word, including any write committed on an earlier edge, and pushes it into the response queue along with an age counter = 0.
- Age: increments every cycle while queued, saturating at LATENCY.
- Response: data_ok=1 in the cycle where the head entry's age == LATENCY, i.e. exactly LATENCY cycles after its accept cycle. rdata = the head's captured word; the head pops at that edge.
  - Writes also get a data_ok; rdata is don't-care for them, driven as the pre-write word.
- Ordering: responses are strictly in accept order. Because latency is uniform, the head is always the oldest entry.
- Push and pop in the same cycle: occupancy is unchanged.
- At most one data_ok per cycle and at most one accept per cycle.
- Write byte enables:
  - size 0: 1 << addr[1:0].
  - size 1: 4'b0011 << addr[1:0].
  - size 2/3: 4'b1111.
- Misalignment (size 1 with addr[0]=1; size 2/3 with addr[1:0]!=0):
  - The request is still accepted and still answered.
  - A write is suppressed entirely (no byte changes).
  - A read returns the aligned word normally.
  - misalign_err pulses in the accept cycle.
- req while addr_ok=0: ignored. The master must hold it; the slave keeps no state about it.
- stall_inject: blocks new accepts only. Queued entries keep ageing and respond on schedule.
- Reset mid-operation: all queued entries are discarded and no data_ok is emitted for them. Writes accepted before reset remain in RAM.
- Internal state: per-entry valid/age/data; head and tail pointers wrap modulo DEPTH.

Decomposition:
- Shared package (sram_like_pkg): SIZE_BYTE=2'd0, SIZE_HALF=2'd1, SIZE_WORD=2'd2; a byte-enable function taking (size, addr[1:0]); and a misalign predicate.
- One sub-module, sram_like_resp_queue: a DEPTH-entry FIFO of {data[31:0], age} with push/pop, occupancy and head outputs, and the age-compare generating head_ready.
- The RAM array and accept logic stay in the top module.

Test Plan (LATENCY=2, DEPTH=2 unless noted):
- Write word 0x12345678 at addr 0x100 (size 2), then read 0x100 → each data_ok arrives exactly 2 cycles after its accept; the read's rdata = 0x12345678; misalign_err stays 0.
- Byte write wdata 0x0000AB00 at 0x101 (size 0), then read 0x100 → rdata = 0x1234AB78. Halfword write 0xBEEF0000 at 0x102 → a read gives 0xBEEFAB78.
- Four back-to-back reads with req held high from cycle 0 → accepts in cycles 0, 1, 3, 4; data_ok in cycles 2, 3, 5, 6; addr_ok low in cycles 2 and 5; outstanding never exceeds 2.
- Word write 0xDEADBEEF at 0x102 (misaligned) → accepted; misalign_err pulses in the accept cycle; data_ok 2 cycles later; a subsequent read of 0x100 is unchanged at 0xBEEFAB78.
- stall_inject=1 for cycles 1–5 with one read accepted in cycle 0 → data_ok still in cycle 2; no accept in cycles 1–5; the next accept occurs in cycle 6.
- LATENCY=1, DEPTH=1: read accepted in cycle 0, rstn pulsed low in cycle 1 → no data_ok ever for that read; all outputs are 0 during reset; after release, a fresh read completes normally and earlier writes are preserved.
